// File: rtl/sw_pkg.sv
// Shared definitions for the sw_pe_gen2 processing element: score range
// limits, traceback direction encoding and default widths.
package sw_pkg;

    localparam int SCORE_W_DEF = 12;
    localparam int SYM_W_DEF   = 2;

    // Source of the winning V term, reported on tb_dir when traceback is built.
    localparam logic [1:0] DIR_ZERO = 2'd0;
    localparam logic [1:0] DIR_DIAG = 2'd1;
    localparam logic [1:0] DIR_UP   = 2'd2;
    localparam logic [1:0] DIR_LEFT = 2'd3;

    // Most-negative representable score at width w.
    function automatic longint negMin(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Most-positive representable score at width w.
    function automatic longint posMax(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

endpackage

// File: rtl/sw_sat_add.sv
// Signed saturating adder: sums at W+1 bits and clamps to the W-bit range,
// so score arithmetic never wraps.
module sw_sat_add #(
    parameter int W = 12
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum
);

    logic signed [W:0] full;

    assign full = {a[W-1], a} + {b[W-1], b};

    // Overflow shows as the two top bits disagreeing; the top bit gives the direction.
    always_comb begin
        sum = full[W-1:0];
        if (full[W] != full[W-1])
            sum = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end

endmodule

// File: rtl/sw_pe_gen2.sv
// Smith-Waterman / Needleman-Wunsch processing element, generation 2.
// Holds one query symbol and scores one DP cell per valid, enabled beat with
// affine gaps, saturating arithmetic, local/global mode and best tracking.
// Optional traceback outputs are built when SW_PE_TRACEBACK_EN is defined.
module sw_pe_gen2
    import sw_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int SYM_W   = SYM_W_DEF,
    parameter int COL_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode_local,
    input  logic                      s_load,
    input  logic [SYM_W-1:0]          s_in,
    input  logic                      valid_in,
    input  logic                      newline_in,
    input  logic [SYM_W-1:0]          t_in,
    input  logic signed [SCORE_W-1:0] v_in,
    input  logic signed [SCORE_W-1:0] v_in_alpha,
    input  logic signed [SCORE_W-1:0] f_in,
    input  logic signed [SCORE_W-1:0] minus_alpha,
    input  logic signed [SCORE_W-1:0] minus_beta,
    input  logic signed [SCORE_W-1:0] match,
    input  logic signed [SCORE_W-1:0] mismatch,
    output logic                      valid_out,
    output logic                      newline_out,
    output logic [SYM_W-1:0]          t_out,
    output logic signed [SCORE_W-1:0] v_out,
    output logic signed [SCORE_W-1:0] v_out_alpha,
    output logic signed [SCORE_W-1:0] f_out,
    output logic signed [SCORE_W-1:0] best_score,
    output logic [COL_W-1:0]          best_col
`ifdef SW_PE_TRACEBACK_EN
    ,
    output logic [1:0]                tb_dir,
    output logic                      tb_e_open,
    output logic                      tb_f_open
`endif
);

    localparam int STAGES = 1;
    localparam logic signed [SCORE_W-1:0] NEG_MIN = SCORE_W'(negMin(SCORE_W));

    logic [STAGES:0]            vldPipe;
    logic [SYM_W-1:0]           sReg;
    logic signed [SCORE_W-1:0]  diagReg, preE;
    logic [COL_W-1:0]           colCnt, curCol;

    logic signed [SCORE_W-1:0]  base, symScore, pe;
    logic signed [SCORE_W-1:0]  diag, eExt, fExt, e, f, v, vAlpha;
`ifdef SW_PE_TRACEBACK_EN
    logic [1:0]                 dir;
    logic                       eOpen, fOpen;
`endif

    assign vldPipe[0] = valid_in;
    assign valid_out  = vldPipe[STAGES];

    // A newline restarts the row: diagonal from 0, E from the mode's boundary.
    assign base     = newline_in ? '0 : diagReg;
    assign symScore = (sReg == t_in) ? match : mismatch;
    assign pe       = newline_in ? (mode_local ? '0 : NEG_MIN) : preE;
    assign curCol   = newline_in ? '0 : colCnt;

    sw_sat_add #(.W(SCORE_W)) uDiag  (.a(base),       .b(symScore),    .sum(diag));
    sw_sat_add #(.W(SCORE_W)) uEExt  (.a(pe),         .b(minus_beta),  .sum(eExt));
    sw_sat_add #(.W(SCORE_W)) uFExt  (.a(f_in),       .b(minus_beta),  .sum(fExt));
    sw_sat_add #(.W(SCORE_W)) uAlpha (.a(v),          .b(minus_alpha), .sum(vAlpha));

    // Gap terms: open (fresh V plus alpha) versus extend (previous gap plus beta).
    assign e = (v_out_alpha >= eExt) ? v_out_alpha : eExt;
    assign f = (v_in_alpha  >= fExt) ? v_in_alpha  : fExt;
`ifdef SW_PE_TRACEBACK_EN
    assign eOpen = (v_out_alpha >= eExt);
    assign fOpen = (v_in_alpha  >= fExt);
`endif

    // Cell max; strict compares give ties to diag, then up, then left, then floor.
    always_comb begin
        v = diag;
`ifdef SW_PE_TRACEBACK_EN
        dir = DIR_DIAG;
`endif
        if (e > v) begin
            v = e;
`ifdef SW_PE_TRACEBACK_EN
            dir = DIR_UP;
`endif
        end
        if (f > v) begin
            v = f;
`ifdef SW_PE_TRACEBACK_EN
            dir = DIR_LEFT;
`endif
        end
        if (mode_local && (v < 0)) begin
            v = '0;
`ifdef SW_PE_TRACEBACK_EN
            dir = DIR_ZERO;
`endif
        end
    end

    // Pipeline and state registers; en=0 freezes everything, bubbles hold data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vldPipe[STAGES:1] <= '0;
            newline_out       <= 1'b0;
            t_out             <= '0;
            v_out             <= '0;
            v_out_alpha       <= '0;
            f_out             <= '0;
            sReg              <= '0;
            diagReg           <= '0;
            preE              <= '0;
            colCnt            <= '0;
            best_score        <= NEG_MIN;
            best_col          <= '0;
`ifdef SW_PE_TRACEBACK_EN
            tb_dir            <= '0;
            tb_e_open         <= 1'b0;
            tb_f_open         <= 1'b0;
`endif
        end else if (en) begin
            vldPipe[STAGES:1] <= vldPipe[STAGES-1:0];
            newline_out       <= valid_in & newline_in;
            t_out             <= t_in;
            if (s_load)
                sReg <= s_in;
            if (valid_in) begin
                v_out       <= v;
                v_out_alpha <= vAlpha;
                f_out       <= f;
                preE        <= e;
                diagReg     <= v_in;
                if (newline_in)
                    colCnt <= COL_W'(1);
                else if (colCnt != '1)
                    colCnt <= colCnt + COL_W'(1);
                if (newline_in || (v > best_score)) begin
                    best_score <= v;
                    best_col   <= curCol;
                end
`ifdef SW_PE_TRACEBACK_EN
                tb_dir    <= dir;
                tb_e_open <= eOpen;
                tb_f_open <= fOpen;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sw_pe_gen2.sv
// Directed self-checking bench for sw_pe_gen2 (SCORE_W=12, SYM_W=2).
module tb_sw_pe_gen2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0, mode_local = 1'b1, s_load = 1'b0;
    logic [1:0] s_in = '0, t_in = '0;
    logic valid_in = 1'b0, newline_in = 1'b0;
    logic signed [11:0] v_in = '0, v_in_alpha = '0, f_in = '0;
    logic signed [11:0] minus_alpha = -12'sd3, minus_beta = -12'sd1;
    logic signed [11:0] match = 12'sd2, mismatch = -12'sd1;
    logic valid_out, newline_out;
    logic [1:0] t_out;
    logic signed [11:0] v_out, v_out_alpha, f_out, best_score;
    logic [15:0] best_col;
`ifdef SW_PE_TRACEBACK_EN
    logic [1:0] tb_dir;
    logic tb_e_open, tb_f_open;
`endif

    int nCmp = 0;
    int nBad = 0;

    sw_pe_gen2 dut (
        .clk(clk), .rst(rst), .en(en), .mode_local(mode_local),
        .s_load(s_load), .s_in(s_in), .valid_in(valid_in), .newline_in(newline_in),
        .t_in(t_in), .v_in(v_in), .v_in_alpha(v_in_alpha), .f_in(f_in),
        .minus_alpha(minus_alpha), .minus_beta(minus_beta), .match(match), .mismatch(mismatch),
        .valid_out(valid_out), .newline_out(newline_out), .t_out(t_out),
        .v_out(v_out), .v_out_alpha(v_out_alpha), .f_out(f_out),
        .best_score(best_score), .best_col(best_col)
`ifdef SW_PE_TRACEBACK_EN
        , .tb_dir(tb_dir), .tb_e_open(tb_e_open), .tb_f_open(tb_f_open)
`endif
    );

    always #5 clk = ~clk;

    // Apply one beat of inputs and advance to 1 time unit after the edge.
    task automatic drive(input logic e, input logic vld, input logic nl, input logic [1:0] t,
                         input int vin, input int vina, input int fin);
        en = e; valid_in = vld; newline_in = nl; t_in = t;
        v_in = 12'(vin); v_in_alpha = 12'(vina); f_in = 12'(fin);
        @(posedge clk); #1;
    endtask

    // Reset plus default constants and query symbol A loaded.
    task automatic startClean(input logic local_mode);
        mode_local = local_mode;
        match = 12'sd2; mismatch = -12'sd1; minus_alpha = -12'sd3; minus_beta = -12'sd1;
        rst = 1'b0; s_load = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 0);
        rst = 1'b1;
        s_load = 1'b1; s_in = 2'd0;
        drive(1'b1, 1'b0, 1'b0, 2'd0, 0, 0, 0);
        s_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 2'd2, 5, 5, 5);
        nCmp++;
        if ({valid_out, newline_out, t_out, v_out, v_out_alpha, f_out} !== '0) begin
            nBad++;
            $display("FAIL reset_outputs got v=%0d va=%0d f=%0d vld=%b want all 0",
                     v_out, v_out_alpha, f_out, valid_out);
        end
        nCmp++;
        if (best_score !== -12'sd2048 || best_col !== 16'd0) begin
            nBad++;
            $display("FAIL reset_best got %0d/%0d want -2048/0", best_score, best_col);
        end
    endtask

    task automatic test_local();
        startClean(1'b1);
        drive(1'b1, 1'b1, 1'b1, 2'd0, 0, -3, -3);
        nCmp++;
        if ({valid_out, newline_out, v_out, v_out_alpha, f_out} !== {1'b1, 1'b1, 12'sd2, -12'sd1, -12'sd3}) begin
            nBad++;
            $display("FAIL local_b0 got v=%0d va=%0d f=%0d vld=%b nl=%b want 2/-1/-3/1/1",
                     v_out, v_out_alpha, f_out, valid_out, newline_out);
        end
        drive(1'b1, 1'b1, 1'b0, 2'd1, 0, -3, -3);
        nCmp++;
        if ({v_out, v_out_alpha, newline_out} !== {12'sd0, -12'sd3, 1'b0}) begin
            nBad++;
            $display("FAIL local_b1 got v=%0d va=%0d nl=%b want 0/-3/0", v_out, v_out_alpha, newline_out);
        end
        nCmp++;
        if (best_score !== 12'sd2 || best_col !== 16'd0) begin
            nBad++;
            $display("FAIL local_best got %0d/%0d want 2/0", best_score, best_col);
        end
    endtask

    task automatic test_global();
        startClean(1'b0);
        drive(1'b1, 1'b1, 1'b1, 2'd0, 0, -3, -3);
        nCmp++;
        if ({v_out, v_out_alpha} !== {12'sd2, -12'sd1}) begin
            nBad++;
            $display("FAIL global_b0 got v=%0d va=%0d want 2/-1", v_out, v_out_alpha);
        end
        drive(1'b1, 1'b1, 1'b0, 2'd1, 0, -3, -3);
        nCmp++;
        if ({v_out, v_out_alpha} !== {-12'sd1, -12'sd4}) begin
            nBad++;
            $display("FAIL global_b1 got v=%0d va=%0d want -1/-4", v_out, v_out_alpha);
        end
        nCmp++;
        if (best_score !== 12'sd2 || best_col !== 16'd0) begin
            nBad++;
            $display("FAIL global_best got %0d/%0d want 2/0", best_score, best_col);
        end
    endtask

    task automatic test_saturation();
        startClean(1'b1);
        drive(1'b1, 1'b1, 1'b1, 2'd0, 2046, -3, -3);
        match = 12'sd5;
        drive(1'b1, 1'b1, 1'b0, 2'd0, 0, -3, -3);
        nCmp++;
        if ({v_out, v_out_alpha} !== {12'sd2047, 12'sd2044}) begin
            nBad++;
            $display("FAIL sat_pos got v=%0d va=%0d want 2047/2044", v_out, v_out_alpha);
        end
        nCmp++;
        if (best_score !== 12'sd2047 || best_col !== 16'd1) begin
            nBad++;
            $display("FAIL sat_best got %0d/%0d want 2047/1", best_score, best_col);
        end
    endtask

    task automatic test_stall_bubble();
        startClean(1'b1);
        drive(1'b1, 1'b1, 1'b1, 2'd0, 0, -3, -3);
        // Stalled beats carry a cell and an s_load; none of it may take effect.
        s_load = 1'b1; s_in = 2'd1;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 2'd1, 0, -3, -3);
        s_load = 1'b0;
        nCmp++;
        if ({valid_out, newline_out, v_out, v_out_alpha, best_score} !== {1'b1, 1'b1, 12'sd2, -12'sd1, 12'sd2}) begin
            nBad++;
            $display("FAIL stall_hold got v=%0d va=%0d best=%0d vld=%b nl=%b want 2/-1/2/1/1",
                     v_out, v_out_alpha, best_score, valid_out, newline_out);
        end
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b1, 2'd3, 9, 9, 9);
        nCmp++;
        if ({valid_out, newline_out, t_out, v_out, v_out_alpha, f_out} !== {1'b0, 1'b0, 2'd3, 12'sd2, -12'sd1, -12'sd3}) begin
            nBad++;
            $display("FAIL bubble_hold got vld=%b nl=%b t=%0d v=%0d va=%0d f=%0d want 0/0/3/2/-1/-3",
                     valid_out, newline_out, t_out, v_out, v_out_alpha, f_out);
        end
        drive(1'b1, 1'b1, 1'b0, 2'd1, 0, -3, -3);
        nCmp++;
        if ({valid_out, v_out, v_out_alpha, best_score, best_col} !== {1'b1, 12'sd0, -12'sd3, 12'sd2, 16'd0}) begin
            nBad++;
            $display("FAIL stall_resume got vld=%b v=%0d va=%0d best=%0d col=%0d want 1/0/-3/2/0",
                     valid_out, v_out, v_out_alpha, best_score, best_col);
        end
    endtask

    task automatic test_sload_valid();
        startClean(1'b1);
        s_load = 1'b1; s_in = 2'd1;
        drive(1'b1, 1'b1, 1'b1, 2'd0, 0, -3, -3);
        s_load = 1'b0;
        nCmp++;
        if (v_out !== 12'sd2) begin
            nBad++;
            $display("FAIL sload_old_sym got v=%0d want 2", v_out);
        end
        drive(1'b1, 1'b1, 1'b0, 2'd0, 0, -3, -3);
        nCmp++;
        if (v_out !== 12'sd0) begin
            nBad++;
            $display("FAIL sload_new_sym got v=%0d want 0", v_out);
        end
    endtask

    task automatic test_tie_column();
        startClean(1'b1);
        match = 12'sd3;
        drive(1'b1, 1'b1, 1'b1, 2'd0, 2, -3, -3);
        nCmp++;
        if (v_out !== 12'sd3 || best_col !== 16'd0) begin
            nBad++;
            $display("FAIL tie_c0 got v=%0d col=%0d want 3/0", v_out, best_col);
        end
        drive(1'b1, 1'b1, 1'b0, 2'd0, 2, -3, -3);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 2, -3, -3);
        nCmp++;
        if ({v_out, best_score, best_col} !== {12'sd5, 12'sd5, 16'd1}) begin
            nBad++;
            $display("FAIL tie_keep_first got v=%0d best=%0d col=%0d want 5/5/1", v_out, best_score, best_col);
        end
`ifdef SW_PE_TRACEBACK_EN
        nCmp++;
        if (tb_dir !== 2'd1) begin
            nBad++;
            $display("FAIL tb_dir_diag got %0d want 1", tb_dir);
        end
`endif
        drive(1'b1, 1'b1, 1'b1, 2'd1, 0, -3, -3);
        nCmp++;
        if ({v_out, best_score, best_col, newline_out} !== {12'sd2, 12'sd2, 16'd0, 1'b1}) begin
            nBad++;
            $display("FAIL tie_newline got v=%0d best=%0d col=%0d nl=%b want 2/2/0/1",
                     v_out, best_score, best_col, newline_out);
        end
`ifdef SW_PE_TRACEBACK_EN
        nCmp++;
        if (tb_dir !== 2'd2 || tb_e_open !== 1'b1) begin
            nBad++;
            $display("FAIL tb_dir_up got %0d/%b want 2/1", tb_dir, tb_e_open);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_local();
        test_global();
        test_saturation();
        test_stall_bubble();
        test_sload_valid();
        test_tie_column();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/sw_pe_gen2.md
Name: sw_pe_gen2

Overview:
- Second-generation Smith-Waterman/Needleman-Wunsch processing element for the systolic alignment array.
- Holds one query symbol and computes one DP cell per valid beat: diagonal match/mismatch, affine E (up) and F (left) gaps.
- Adds a wider signed saturating datapath, configurable alphabet, pipeline stall and valid qualification, local/global mode, and per-PE best-score/column tracking.
- Instances chain left to right; the array top reduces the per-PE best scores.

Parameters:
- SCORE_W, 12, signed two's-complement width of V/E/F and all penalties.
- SYM_W, 2, symbol width (2 = DNA, 5 = protein).
- COL_W, 16, width of the column counter and best-column index.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- en  in  1  global pipeline enable; 0 = stall, every register holds
- mode_local  in  1  1 = local (floor at 0), 0 = global (no floor); static during an alignment
- s_load  in  1  load s_in into the query-symbol register
- s_in  in  SYM_W  query symbol to load
- valid_in  in  1  beat carries a cell
- newline_in  in  1  first cell of a new target sequence
- t_in  in  SYM_W  target symbol
- v_in  in  SCORE_W  V from the left neighbour (becomes next beat's diagonal)
- v_in_alpha  in  SCORE_W  left V plus gap-open
- f_in  in  SCORE_W  F from the left neighbour
- minus_alpha, minus_beta, match, mismatch  in  SCORE_W each  signed scoring constants (penalties negative)
- valid_out, newline_out  out  1  registered copies of valid_in and newline_in
- t_out  out  SYM_W  registered t_in
- v_out, v_out_alpha, f_out  out  SCORE_W  registered cell results
- best_score  out  SCORE_W  maximum V seen in the current target
- best_col  out  COL_W  column index of best_score

Behaviour:
- Reset: rst, asynchronous, active-low; clock clk. All outputs, s_reg, diag_reg, pre_e and col_cnt reset to 0; best_score resets to the most-negative value.
- Latency is 1 enabled cycle from an input beat to its outputs. With en=0 nothing changes, including the s_load effect.
- Bubble (en=1, valid_in=0):
  - valid_out<=0 and newline_out<=0.
  - Data outputs, diag_reg, pre_e, col_cnt and best are held.
  - t_out still follows t_in.
- Cell computation (en=1, valid_in=1):
  - diag = base + (s_reg==t_in ? match : mismatch). base = 0 when newline_in, else diag_reg.
  - e = max(pe + minus_beta, v_out_alpha). pe = NEG_MIN when newline_in in global mode, 0 when newline_in in local mode, else pre_e.
  - f = max(v_in_alpha, f_in + minus_beta).
  - v = max(diag, e, f, mode_local ? 0 : NEG_MIN).
  - Registered: v_out<=v, v_out_alpha<=v+minus_alpha, f_out<=f, pre_e<=e, diag_reg<=v_in.
- Arithmetic: every add is performed at SCORE_W+1 bits, then saturated to [NEG_MIN = -2^(SCORE_W-1), POS_MAX = 2^(SCORE_W-1)-1]. Wrap-around must never occur.
- Column counter: newline beat gives col_cnt<=1 and current column 0; otherwise current column = col_cnt and col_cnt increments, saturating at all-ones.
- Best tracking on a valid beat:
  - newline: best_score<=v, best_col<=0.
  - otherwise, if v > best_score (strictly), best updates with the current column. Ties keep the earliest column.
- s_load together with valid_in: the cell uses the old s_reg; the new symbol applies from the next beat. s_load while en=0 is ignored.
- Asynchronous reset during an alignment discards it; the next alignment must start with a newline beat.

Optional Feature:
- Macro SW_PE_TRACEBACK_EN.
- When defined, adds output tb_dir (2 bits, registered with valid_out, reset 0) giving the source of v: 0 = zero floor, 1 = diag, 2 = up (E), 3 = left (F).
- Tie priority: diag > up > left > floor.
- Also adds tb_e_open and tb_f_open (1 bit each) = 1 when the gap-open term won in e and in f respectively.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package sw_pkg: NEG_MIN/POS_MAX functions of SCORE_W, the tb_dir encoding constants, and the default SCORE_W/SYM_W.
- One sub-module, sw_sat_add: parameterised signed saturating adder, instantiated for every add (diag, e, f, v_out_alpha).
- Max selection is inline combinational logic.

Test Plan:
- Local mode, SCORE_W=12, match=2, mismatch=-1, alpha=-3, beta=-1, s=A; stream newline+A then C, with v_in=0 and v_in_alpha/f_in=-3 -> v_out=2 then 0 (clamped); best_score=2, best_col=0.
- Global mode, same stream -> v_out=2 then -1 (diag 0 + mismatch); no floor applied; best unchanged at 2.
- Saturation: diag_reg=2046, match=5 -> v_out=2047; v_out_alpha=2044; no wrap to negative.
- Stall/bubble: assert en=0 for 3 cycles mid-stream, then valid_in=0 for 2 beats -> outputs and best identical to the no-stall run, with valid_out low only for the bubbles.
- s_load with valid beat: s_reg=A, load C while a cell with t=A is valid -> that cell scores match; the next t=A scores mismatch.
- Tie/column: V sequence 3,5,5 over columns 0,1,2 -> best_col=1. A newline then resets best_col to 0. With SW_PE_TRACEBACK_EN, check tb_dir=1 on the diag wins.
